// File: rtl/status_cond_unit_pkg.sv
// Shared ARM condition-code and NZCV flag definitions (ALU, control unit, status unit).
package status_cond_unit_pkg;

    localparam int unsigned COND_W = 4;
    localparam int unsigned FLAGS_W = 4;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/status_cond_unit_cond_check.sv
// ARM condition-field evaluator: 4-bit cond against NZCV flags, purely combinational.
module cond_check
    import status_cond_unit_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               pass_c
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = flags[FLAG_N];
    assign z_flag = flags[FLAG_Z];
    assign c_flag = flags[FLAG_C];
    assign v_flag = flags[FLAG_V];

    // Decode the condition mnemonic against the selected flags.
    always_comb begin
        pass_c = 1'b0;
        unique case (cond)
            COND_EQ: pass_c = z_flag;
            COND_NE: pass_c = !z_flag;
            COND_CS: pass_c = c_flag;
            COND_CC: pass_c = !c_flag;
            COND_MI: pass_c = n_flag;
            COND_PL: pass_c = !n_flag;
            COND_VS: pass_c = v_flag;
            COND_VC: pass_c = !v_flag;
            COND_HI: pass_c = c_flag && !z_flag;
            COND_LS: pass_c = !c_flag || z_flag;
            COND_GE: pass_c = (n_flag == v_flag);
            COND_LT: pass_c = (n_flag != v_flag);
            COND_GT: pass_c = !z_flag && (n_flag == v_flag);
            COND_LE: pass_c = z_flag || (n_flag != v_flag);
            COND_AL: pass_c = 1'b1;
            COND_NV: pass_c = 1'b0;
            default: pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// NZCV status register, ID condition check with EXE flag forwarding,
// EXE execute tracking and a saturating count of condition-failed instructions.
module status_cond_unit
    import status_cond_unit_pkg::*;
#(
    parameter bit          FORWARD = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [COND_W-1:0]  id_cond,
    input  logic               exe_s,
    input  logic [FLAGS_W-1:0] alu_status,
    output logic [FLAGS_W-1:0] status_q,
    output logic               alu_carry,
    output logic               id_cond_pass,
    output logic               exe_exec,
    output logic               flag_we,
    output logic [CNT_W-1:0]   skip_cnt
);

    logic [FLAGS_W-1:0] eff_flags_c;
    logic               skip_event_c;

    // An S-instruction only writes flags when it really executes.
    assign flag_we = exe_exec & exe_s;

    // The ALU always consumes committed flags, never forwarded ones.
    assign alu_carry = status_q[FLAG_C];

    // Let the ID check see flags being written by EXE this cycle.
    assign eff_flags_c = (FORWARD && flag_we) ? alu_status : status_q;

    cond_check u_cond_check (
        .cond   (id_cond),
        .flags  (eff_flags_c),
        .pass_c (id_cond_pass)
    );

    // Counted only for real instructions that actually leave ID this cycle.
    assign skip_event_c = id_valid & ~id_cond_pass & ~freeze & ~flush;

    // Architectural status register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else if (flag_we) begin
            status_q <= alu_status;
        end
    end

    // EXE execute flag; flush and freeze both insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_exec <= 1'b0;
        end else if (flush) begin
            exe_exec <= 1'b0;
        end else if (freeze) begin
            exe_exec <= 1'b0;
        end else begin
            exe_exec <= id_valid & id_cond_pass;
        end
    end

    // Saturating skipped-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (skip_event_c && (skip_cnt != '1)) begin
            skip_cnt <= skip_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench: a forwarding 16-bit-counter instance and a
// non-forwarding 4-bit-counter instance driven in parallel against a model.
module tb_status_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       freeze;
    logic       flush;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       exe_s;
    logic [3:0] alu_status;

    logic [3:0]  s0_status, s1_status;
    logic        s0_carry,  s1_carry;
    logic        s0_pass,   s1_pass;
    logic        s0_exec,   s1_exec;
    logic        s0_fwe,    s1_fwe;
    logic [15:0] s0_skip;
    logic [3:0]  s1_skip;

    int n_chk = 0;
    int n_err = 0;

    // model state per instance (0: forwarding, 1: registered flags only)
    logic [3:0] m_st [2];
    bit         m_ex [2];
    int         m_sk [2];
    bit         fwd  [2] = '{1'b1, 1'b0};
    int         maxv [2] = '{65535, 15};

    always #5 clk = ~clk;

    status_cond_unit #(.FORWARD(1'b1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_cond(id_cond), .exe_s(exe_s),
        .alu_status(alu_status), .status_q(s0_status), .alu_carry(s0_carry),
        .id_cond_pass(s0_pass), .exe_exec(s0_exec), .flag_we(s0_fwe),
        .skip_cnt(s0_skip)
    );

    status_cond_unit #(.FORWARD(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_cond(id_cond), .exe_s(exe_s),
        .alu_status(alu_status), .status_q(s1_status), .alu_carry(s1_carry),
        .id_cond_pass(s1_pass), .exe_exec(s1_exec), .flag_we(s1_fwe),
        .skip_cnt(s1_skip)
    );

    // Condition pairs: even code tests a predicate, odd code its negation.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [3:0] eff_flags(input int k);
        bit fw;
        fw = m_ex[k] && exe_s;
        return (fwd[k] && fw) ? alu_status : m_st[k];
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [3:0]  o_st;
            logic        o_cy, o_ps, o_ex, o_fw;
            logic [31:0] o_sk;
            if (k == 0) begin
                o_st = s0_status; o_cy = s0_carry; o_ps = s0_pass;
                o_ex = s0_exec; o_fw = s0_fwe; o_sk = 32'(s0_skip);
            end else begin
                o_st = s1_status; o_cy = s1_carry; o_ps = s1_pass;
                o_ex = s1_exec; o_fw = s1_fwe; o_sk = 32'(s1_skip);
            end
            chk({tag, ".status_q"}, k, 32'(o_st), 32'(m_st[k]));
            chk({tag, ".alu_carry"}, k, 32'(o_cy), 32'(m_st[k][1]));
            chk({tag, ".exe_exec"}, k, 32'(o_ex), 32'(m_ex[k]));
            chk({tag, ".flag_we"}, k, 32'(o_fw), 32'(m_ex[k] && exe_s));
            chk({tag, ".id_cond_pass"}, k, 32'(o_ps), 32'(ref_pass(id_cond, eff_flags(k))));
            chk({tag, ".skip_cnt"}, k, 32'(o_sk), 32'(m_sk[k]));
        end
    endtask

    // Advance one clock with the currently driven inputs, updating the model.
    task automatic advance();
        logic [3:0] n_st [2];
        bit         n_ex [2];
        int         n_sk [2];
        for (int k = 0; k < 2; k++) begin
            bit fw, p;
            fw = m_ex[k] && exe_s;
            p  = ref_pass(id_cond, eff_flags(k));
            n_st[k] = fw ? alu_status : m_st[k];
            n_ex[k] = !flush && !freeze && id_valid && p;
            n_sk[k] = m_sk[k];
            if (id_valid && !p && !freeze && !flush && m_sk[k] < maxv[k])
                n_sk[k] = m_sk[k] + 1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = n_st[k]; m_ex[k] = n_ex[k]; m_sk[k] = n_sk[k];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 4'h0; m_ex[k] = 1'b0; m_sk[k] = 0;
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input bit s,
                         input logic [3:0] a, input bit fz, input bit fl);
        id_valid = v; id_cond = c; exe_s = s; alu_status = a;
        freeze = fz; flush = fl;
    endtask

    // Commit value f into both status registers via an AL S-instruction.
    task automatic write_status(input logic [3:0] f);
        drive(1'b1, 4'he, 1'b0, 4'h0, 1'b0, 1'b0);
        advance();
        drive(1'b0, 4'he, 1'b1, f, 1'b0, 1'b0);
        advance();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Forwarding: EXE S-instruction writes Z=1 while ID evaluates EQ.
        drive(1'b1, 4'he, 1'b0, 4'h0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 4'h0, 1'b1, 4'b0100, 1'b0, 1'b0);
        #1;
        chk("fwd_eq_pass", 0, 32'(s0_pass), 32'd1);
        chk("nofwd_eq_pass", 1, 32'(s1_pass), 32'd0);
        check_state("fwd");
        advance();
        chk("fwd_commit", 0, 32'(s0_status), 32'h4);
        check_state("fwd_next");

        // Bubble suppression: NE fails with Z=1, then an S-bubble must not write.
        drive(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
        advance();
        chk("bubble_exec", 0, 32'(s0_exec), 32'd0);
        check_state("bubble");
        drive(1'b0, 4'he, 1'b1, 4'b1000, 1'b0, 1'b0);
        #1;
        check_state("bubble_s");
        advance();
        chk("bubble_nowrite", 0, 32'(s0_status), 32'h4);
        check_state("bubble_after");

        // Full decode sweep against committed flags.
        for (int s = 0; s < 16; s++) begin
            write_status(4'(s));
            for (int c = 0; c < 16; c++) begin
                id_cond = 4'(c);
                #0.1;
                chk("sweep_pass", 0, 32'(s0_pass), 32'(ref_pass(4'(c), 4'(s))));
                chk("sweep_pass", 1, 32'(s1_pass), 32'(ref_pass(4'(c), 4'(s))));
            end
        end
        write_status(4'b1001);
        id_cond = 4'hc;
        #0.1;
        chk("gt_1001", 0, 32'(s0_pass), 32'd1);
        write_status(4'b1000);
        id_cond = 4'hd;
        #0.1;
        chk("le_1000", 0, 32'(s0_pass), 32'd1);
        id_cond = 4'hf;
        #0.1;
        chk("nv_never", 0, 32'(s0_pass), 32'd0);

        // freeze+flush together with a failing and a passing instruction.
        drive(1'b1, 4'hf, 1'b0, 4'h0, 1'b1, 1'b1);
        advance();
        check_state("prio_fail");
        drive(1'b1, 4'he, 1'b0, 4'h0, 1'b1, 1'b1);
        advance();
        chk("prio_exec", 0, 32'(s0_exec), 32'd0);
        check_state("prio_al");

        // Carry feed and ADC 5+3+C = 9 committing C=0.
        write_status(4'b0010);
        chk("carry_feed", 0, 32'(s0_carry), 32'd1);
        check_state("carry");
        drive(1'b1, 4'he, 1'b0, 4'h0, 1'b0, 1'b0);
        advance();
        begin
            int sum;
            logic [3:0] f;
            sum = 5 + 3 + int'(m_st[0][1]);
            f = {sum[3], (sum[3:0] == 4'h0), sum[4], 1'b0};
            drive(1'b0, 4'he, 1'b1, f, 1'b0, 1'b0);
            advance();
            chk("adc_carry_out", 0, 32'(s0_carry), 32'd0);
            check_state("adc");
        end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            #1;
            check_state("rand_pre");
            advance();
        end

        // Asynchronous reset mid-cycle with a flag write pending.
        drive(1'b1, 4'he, 1'b0, 4'h0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 4'hf, 1'b1, 4'hf, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'he, 1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_state("post_rst");

        // Saturation: stream of failing NV instructions.
        drive(1'b1, 4'hf, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) advance();
        chk("sat_small", 1, 32'(s1_skip), 32'hf);
        check_state("sat_small");
        while (m_sk[0] < 65535) advance();
        for (int i = 0; i < 3; i++) advance();
        chk("sat_full", 0, 32'(s0_skip), 32'hffff);
        check_state("sat_full");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/status_cond_unit.md
# status_cond_unit

Flag-consumer side of the execute-stage ALU. It holds the architectural NZCV status register, written from the ALU's 4-bit status output {N,Z,C,V} when an executed S-instruction completes, and returns the carry to the ALU for ADC/SBC. It also evaluates the 4-bit ARM condition field of the instruction in ID, forwarding in-flight EXE flags, and tracks whether the instruction in EXE actually executes. It sits between the ID/EXE pipeline register, the ALU and the hazard unit.

## Interface
Parameters:
- FORWARD, 1: 1 = condition check sees EXE-stage flags being written this cycle; 0 = uses registered flags only.
- CNT_W, 16: width of the skipped-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall: ID holds, EXE receives a bubble.
- flush  in  1  branch flush: the ID instruction is discarded, EXE receives a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_cond  in  4  condition field [31:28] of the ID instruction.
- exe_s  in  1  S bit of the instruction currently in EXE.
- alu_status  in  4  ALU flags {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V.
- status_q  out  4  registered NZCV, same bit order.
- alu_carry  out  1  = status_q[1]; drives the ALU C input.
- id_cond_pass  out  1  combinational: the ID instruction's condition holds.
- exe_exec  out  1  registered: the EXE instruction executes (passed its condition, not a bubble).
- flag_we  out  1  combinational: exe_exec & exe_s.
- skip_cnt  out  CNT_W  saturating count of condition-failed instructions.

## Operation
- Effective flags: eff = (FORWARD && flag_we) ? alu_status : status_q.
- Condition decode on eff. EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C. MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
- HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V. GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1. NV 1111: 0.
- id_cond_pass depends only on id_cond and eff; it is independent of id_valid.
- Status register: on a clock edge with flag_we=1, status_q <= alu_status. Otherwise it holds. The write uses the ALU flags unmodified.
- exe_exec register, per edge, priority order:
  - flush -> 0.
  - else freeze -> 0 (bubble).
  - else -> id_valid & id_cond_pass.
- skip_cnt increments when id_valid & !id_cond_pass & !freeze & !flush and skip_cnt is not all-ones. At all-ones it holds.

## Timing
- Reset values: status_q=0000, exe_exec=0, skip_cnt=0. Derived outputs at reset: alu_carry=0, flag_we=0.
- rst asserted mid-operation clears all state immediately, regardless of clk. A flag write pending on the next edge is lost.
- Flag latency: an S-instruction in EXE during cycle t updates status_q visibly in cycle t+1. With FORWARD=1, the ID instruction in cycle t already sees these flags.
- alu_carry reflects status_q, never the forwarded value. The ALU instruction in EXE needs the flags committed before it.
- Back-to-back S-instructions: each writes once, in its own EXE cycle. Bubbles (exe_exec=0) never write, even when exe_s=1.
- freeze and flush asserted together: flush priority, exe_exec <= 0, skip_cnt does not count.

## Structure
- Shared package (e.g. arm_pkg):
  - condition-code localparams COND_EQ..COND_NV;
  - flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- The package is shared with the ALU and the control unit.
- One sub-module: cond_check (4-bit cond + 4-bit flags -> pass), purely combinational. It is reusable by the branch unit.
- status_cond_unit contains the forwarding mux, status register, exe_exec register and counter.

## Test plan
- Reset: rst=1 mid-cycle -> status_q=0000, exe_exec=0 and skip_cnt=0 immediately, before the next clk edge.
- Forwarding: exe_exec=1, exe_s=1, alu_status=0100, status_q=0000, id_cond=0000 (EQ) -> id_cond_pass=1 with FORWARD=1, 0 with FORWARD=0. Next cycle status_q=0100.
- Bubble suppression: id_cond=0001 (NE) with eff Z=1 and id_valid=1 -> exe_exec=0 next cycle and skip_cnt +1. The following exe_s=1 with alu_status=1000 -> status_q unchanged.
- Full decode: sweep all 16 id_cond values against all 16 status_q values with no forwarding -> id_cond_pass matches the ARM table, with NV always 0. Spot checks: GT with status_q=1001 -> 1; LE with 1000 -> 1.
- Priority and saturation:
  - freeze=1 and flush=1 with a passing AL instruction -> exe_exec=0, skip_cnt unchanged.
  - Preload skip_cnt to FFFF with failing instructions -> skip_cnt stays FFFF.
- Carry feed: status_q=0010 -> alu_carry=1. ADC of 5+3 through the ALU -> result 9, committed C=0 after the write.
